// File: rtl/instr_mem_loadable.sv
// Instruction memory with a byte-serial program loader and a registered fetch port.
// The loader packs MSB-first bytes into 32-bit words; fetches beyond the loaded image fault.
module instr_mem_loadable #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              rd_en,
  output logic [31:0]       instr,
  output logic              fault,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  input  logic              ld_end,
  output logic              busy,
  output logic [ADDR_W:0]   word_count
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state, nxt;
  logic [31:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   ptr;
  logic [1:0]          bcnt;
  logic [31:0]         shreg;

  logic                acc, wr_full, wr_part, we, last;
  logic [2:0]          nb;
  logic [31:0]         nsh, wdata;

  logic [ADDR_W-1:0]   idx;
  logic                fault_c;

  assign busy     = (state == LOAD);
  assign ld_ready = busy & ~ld_start;
  assign acc      = ld_valid & ld_ready;

  always_comb begin
    nb      = {1'b0, bcnt} + {2'b00, acc};
    nsh     = acc ? {shreg[23:0], ld_byte} : shreg;
    wr_full = busy & ~ld_start & (nb == 3'd4);
    // A flush only happens when bytes are held; an empty ld_end just closes the load.
    wr_part = busy & ~ld_start & ld_end & ~wr_full & (nb != 3'd0);
    we      = wr_full | wr_part;
    last    = wr_full & (&ptr);
    case (nb)
      3'd1:    wdata = {nsh[7:0],  24'h0};
      3'd2:    wdata = {nsh[15:0], 16'h0};
      3'd3:    wdata = {nsh[23:0], 8'h0};
      default: wdata = nsh;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (ld_start) nxt = LOAD;
      LOAD: begin
        if (ld_start)             nxt = LOAD;
        else if (ld_end || last)  nxt = DONE;
      end
      default:                    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      word_count <= '0;
    end else begin
      state <= nxt;
      if (ld_start) begin
        ptr        <= '0;
        bcnt       <= '0;
        shreg      <= '0;
        word_count <= '0;
      end else if (busy) begin
        if (we) begin
          ptr        <= ptr + 1'b1;
          word_count <= word_count + 1'b1;
          bcnt       <= '0;
          shreg      <= '0;
        end else if (acc) begin
          bcnt  <= nb[1:0];
          shreg <= nsh;
        end
      end
    end
  end

  // Array is deliberately outside reset; word_count alone gates what is reachable.
  always_ff @(posedge clk) begin
    if (!reset && we) mem[ptr] <= wdata;
  end

  assign idx     = addr[ADDR_W+1:2];
  assign fault_c = (|addr[1:0]) | (|addr[31:ADDR_W+2]) | ({1'b0, idx} >= word_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= NOP_WORD;
      fault <= 1'b0;
    end else if (rd_en) begin
      if (busy) begin
        instr <= NOP_WORD;
        fault <= 1'b0;
      end else if (fault_c) begin
        instr <= NOP_WORD;
        fault <= 1'b1;
      end else begin
        instr <= mem[idx];
        fault <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench: two instances (ADDR_W=8 and ADDR_W=2) share one stimulus stream.
module tb_instr_mem_loadable;
  logic        clk = 1'b0;
  logic        reset, rd_en, ld_start, ld_valid, ld_end;
  logic [31:0] addr;
  logic [7:0]  ld_byte;

  logic [31:0] instr8, instr2;
  logic        fault8, fault2, rdy8, rdy2, busy8, busy2;
  logic [8:0]  wc8;
  logic [2:0]  wc2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_mem_loadable #(.ADDR_W(8)) u8 (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .instr(instr8), .fault(fault8),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(rdy8),
    .ld_end(ld_end), .busy(busy8), .word_count(wc8));

  instr_mem_loadable #(.ADDR_W(2)) u2 (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .instr(instr2), .fault(fault2),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(rdy2),
    .ld_end(ld_end), .busy(busy2), .word_count(wc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start;
    ld_start = 1'b1; tick; ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    ld_valid = 1'b1; ld_byte = b; ld_end = e;
    tick;
    ld_valid = 1'b0; ld_end = 1'b0;
  endtask

  task automatic endld;
    ld_end = 1'b1; tick; ld_end = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    addr = a; rd_en = 1'b1; tick; rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_en = 0; ld_start = 0; ld_valid = 0; ld_end = 0; addr = 0; ld_byte = 0;
    tick; tick;
    reset = 1'b0;
    chk("rst_instr", instr8, 32'h0);
    chk("rst_fault", {31'b0, fault8}, 32'h0);
    chk("rst_busy",  {31'b0, busy8},  32'h0);
    chk("rst_ready", {31'b0, rdy8},   32'h0);
    chk("rst_wc",    {23'b0, wc8},    32'h0);

    // Load two words, with a busy-time fetch in the middle
    ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'hFF;
    #1 chk("ready_at_start", {31'b0, rdy8}, 32'h0);
    tick; ld_start = 1'b0; ld_valid = 1'b0;
    fetch(32'h0);
    chk("busy_instr", instr8, 32'h0);
    chk("busy_fault", {31'b0, fault8}, 32'h0);
    chk("busy_flag",  {31'b0, busy8},  32'h1);
    send(8'h3C, 0); send(8'h01, 0); send(8'h40, 0); send(8'h00, 0);
    send(8'h34, 0); send(8'h31, 0); send(8'h00, 0); send(8'h1C, 0);
    endld;
    chk("load_wc",   {23'b0, wc8},   32'd2);
    chk("load_busy", {31'b0, busy8}, 32'h0);
    fetch(32'h0);
    chk("fetch0", instr8, 32'h3c014000);
    chk("fetch0_fault", {31'b0, fault8}, 32'h0);
    fetch(32'h4);
    chk("fetch4", instr8, 32'h3431001c);
    chk("fetch4_u2", instr2, 32'h3431001c);
    addr = 32'h0; tick; tick; tick;
    chk("stall_hold", instr8, 32'h3431001c);
    fetch(32'h2);
    chk("misalign_fault", {31'b0, fault8}, 32'h1);
    chk("misalign_instr", instr8, 32'h0);
    fetch(32'h4);
    chk("refetch_fault", {31'b0, fault8}, 32'h0);
    fetch(32'h8);
    chk("beyond_wc_fault", {31'b0, fault8}, 32'h1);
    fetch(32'h4);
    fetch(32'h400);
    chk("range_fault", {31'b0, fault8}, 32'h1);

    // Partial flush: word 1 still holds old data but is now unreachable
    start; send(8'h24, 0); send(8'h10, 0); send(8'h00, 0); endld;
    chk("part_wc", {23'b0, wc8}, 32'd1);
    fetch(32'h0);
    chk("part_word", instr8, 32'h24100000);
    fetch(32'h4);
    chk("stale_fault", {31'b0, fault8}, 32'h1);

    // ld_end together with the final byte
    start; send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    chk("endfull_wc", {23'b0, wc8}, 32'd1);
    fetch(32'h0);
    chk("endfull_word", instr8, 32'h11223344);
    start; send(8'hAA, 0); send(8'hBB, 1);
    fetch(32'h0);
    chk("endpart_word", instr8, 32'haabb0000);

    // Restart after 6 bytes
    start;
    for (int i = 1; i <= 6; i++) send(8'(i), 0);
    chk("pre_restart_wc", {23'b0, wc8}, 32'd1);
    start;
    chk("restart_wc", {23'b0, wc8}, 32'd0);
    chk("restart_busy", {31'b0, busy8}, 32'h1);
    send(8'h0A, 0); send(8'h0B, 0); send(8'h0C, 0); send(8'h0D, 0); endld;
    fetch(32'h0);
    chk("restart_word", instr8, 32'h0a0b0c0d);
    chk("restart_wc_end", {23'b0, wc8}, 32'd1);

    // Reset mid-load drops the partial word
    start; send(8'hEE, 0); send(8'hEE, 0);
    reset = 1'b1; tick; reset = 1'b0;
    chk("midrst_busy", {31'b0, busy8}, 32'h0);
    chk("midrst_wc",   {23'b0, wc8},   32'd0);
    chk("midrst_instr", instr8, 32'h0);
    fetch(32'h0);
    chk("midrst_fault", {31'b0, fault8}, 32'h1);
    start; send(8'h77, 1);
    fetch(32'h0);
    chk("midrst_reload", instr8, 32'h77000000);

    // Full condition on the 4-word instance; the 256-word instance keeps loading
    start;
    for (int i = 1; i <= 20; i++) begin
      ld_valid = 1'b1; ld_byte = 8'(i);
      #1 chk($sformatf("u2_ready_b%0d", i), {31'b0, rdy2}, (i <= 16) ? 32'h1 : 32'h0);
      tick;
    end
    ld_valid = 1'b0;
    chk("full_wc",   {29'b0, wc2},   32'd4);
    chk("full_busy", {31'b0, busy2}, 32'h0);
    endld;
    chk("u8_wc5", {23'b0, wc8}, 32'd5);
    fetch(32'h0);
    chk("full_word0", instr2, 32'h01020304);
    fetch(32'hC);
    chk("full_word3", instr2, 32'h0d0e0f10);
    fetch(32'h10);
    chk("u8_word4", instr8, 32'h11121314);
    chk("u2_range_fault", {31'b0, fault2}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
